// File: rtl/stack_ctrl.sv
// Execute-stage stack sequencer: turns PUSH/POP/CALL/RET/RTI/INT into one or two
// registered stack memory beats and steers the SP unit's increment/decrement.
module stack_ctrl #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  input  logic [2:0]    op_code,
  input  logic [DW-1:0] push_data,
  input  logic [DW-1:0] pc_ret,
  input  logic [3:0]    flags_in,
  input  logic          stall_in,
  input  logic [AW-1:0] sp_bypassed,
  input  logic          sp_not_ready,
  output logic [1:0]    sp_op,
  output logic          busy,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    pop_dest
);

  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;
  localparam logic [2:0] OP_RTI  = 3'b101;
  localparam logic [2:0] OP_INT  = 3'b110;

  localparam logic [1:0] SP_HOLD = 2'b00;
  localparam logic [1:0] SP_DEC  = 2'b01;
  localparam logic [1:0] SP_INC  = 2'b10;

  localparam logic [1:0] DEST_REG   = 2'b00;
  localparam logic [1:0] DEST_PC    = 2'b01;
  localparam logic [1:0] DEST_FLAGS = 2'b10;

  typedef enum logic {IDLE, BEAT2} state_t;

  state_t        state;
  logic          b2_int;
  logic [DW-1:0] pc_lat;

  logic          fire;
  logic          idle_op;
  logic          op_two;
  logic          beat_fire;
  logic          beat_write;
  logic [AW-1:0] beat_addr;
  logic [DW-1:0] beat_wdata;
  logic [1:0]    beat_dest;

  // Beat decode: what the current cycle would issue if it fires
  always_comb begin
    fire       = !stall_in && !sp_not_ready;
    idle_op    = (state == IDLE) && op_valid && (op_code != 3'b000) && (op_code != 3'b111);
    op_two     = (op_code == OP_INT) || (op_code == OP_RTI);
    beat_fire  = !rst && fire && ((state == BEAT2) || idle_op);
    beat_write = 1'b0;
    beat_wdata = pc_lat;
    beat_dest  = DEST_FLAGS;
    if (state == BEAT2) begin
      beat_write = b2_int;
    end else begin
      case (op_code)
        OP_PUSH: begin beat_write = 1'b1; beat_wdata = push_data;      end
        OP_CALL: begin beat_write = 1'b1; beat_wdata = pc_ret;         end
        OP_INT:  begin beat_write = 1'b1; beat_wdata = DW'(flags_in);  end
        OP_POP:  beat_dest = DEST_REG;
        default: beat_dest = DEST_PC;
      endcase
    end
    beat_addr = beat_write ? sp_bypassed : sp_bypassed + AW'(1);
  end

  always_comb begin
    sp_op = SP_HOLD;
    if (beat_fire) sp_op = beat_write ? SP_DEC : SP_INC;
    busy = !rst && ((state == BEAT2) || (idle_op && (sp_not_ready || (fire && op_two))));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      b2_int    <= 1'b0;
      pc_lat    <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pop_dest  <= DEST_REG;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      if (beat_fire) begin
        mem_we   <= beat_write;
        mem_re   <= !beat_write;
        mem_addr <= beat_addr;
        if (beat_write) mem_wdata <= beat_wdata;
        else            pop_dest  <= beat_dest;
        // Two-beat ops park in BEAT2 with the kind and return PC captured
        if (state == IDLE && op_two) begin
          state  <= BEAT2;
          b2_int <= (op_code == OP_INT);
          pc_lat <= pc_ret;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a request scoreboard.
module tb_stack_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic [2:0] op_code;
  logic [7:0] push_data;
  logic [7:0] pc_ret;
  logic [3:0] flags_in;
  logic       stall_in;
  logic [7:0] sp_bypassed;
  logic       sp_not_ready;
  logic [1:0] sp_op;
  logic       busy;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [1:0] pop_dest;

  typedef struct {
    logic       we;
    logic       re;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [1:0] dest;
    string      tag;
  } req_t;

  req_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] last_addr = 8'h00;

  stack_ctrl #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .push_data(push_data), .pc_ret(pc_ret), .flags_in(flags_in),
    .stall_in(stall_in), .sp_bypassed(sp_bypassed), .sp_not_ready(sp_not_ready),
    .sp_op(sp_op), .busy(busy), .mem_we(mem_we), .mem_re(mem_re),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .pop_dest(pop_dest)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] code, input logic [7:0] sp,
                       input logic nr, input logic st);
    op_valid = v; op_code = code; sp_bypassed = sp; sp_not_ready = nr; stall_in = st;
  endtask

  // One clock: check combinational outputs, queue the expected request, then
  // pop and compare it against the registered outputs after the edge.
  task automatic cyc(input string tag, input logic [1:0] e_sp_op, input logic e_busy,
                     input logic e_we, input logic e_re, input logic [7:0] e_addr,
                     input logic [7:0] e_wdata, input logic [1:0] e_dest);
    req_t r;
    #1;
    chk({tag, ".sp_op"}, 32'(sp_op), 32'(e_sp_op));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    exp_q.push_back('{we: e_we, re: e_re, addr: e_addr, wdata: e_wdata, dest: e_dest, tag: tag});
    @(posedge clk);
    #1;
    r = exp_q.pop_front();
    chk({r.tag, ".we"}, 32'(mem_we), 32'(r.we));
    chk({r.tag, ".re"}, 32'(mem_re), 32'(r.re));
    if (r.we || r.re) begin
      chk({r.tag, ".addr"}, 32'(mem_addr), 32'(r.addr));
      last_addr = r.addr;
    end else begin
      chk({r.tag, ".addr_hold"}, 32'(mem_addr), 32'(last_addr));
    end
    if (r.we) chk({r.tag, ".wdata"}, 32'(mem_wdata), 32'(r.wdata));
    if (r.re) chk({r.tag, ".dest"},  32'(pop_dest),  32'(r.dest));
  endtask

  task automatic idle_cyc(input string tag);
    cyc(tag, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
  endtask

  task automatic reset_check(input string tag);
    #1;
    chk({tag, ".sp_op"}, 32'(sp_op), 32'h0);
    chk({tag, ".busy"},  32'(busy),  32'h0);
    @(posedge clk);
    #1;
    chk({tag, ".we"},    32'(mem_we),    32'h0);
    chk({tag, ".re"},    32'(mem_re),    32'h0);
    chk({tag, ".addr"},  32'(mem_addr),  32'h0);
    chk({tag, ".wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, ".dest"},  32'(pop_dest),  32'h0);
    last_addr = 8'h00;
  endtask

  initial begin
    rst = 1'b1;
    push_data = 8'h00; pc_ret = 8'h00; flags_in = 4'h0;
    drive(1'b1, 3'b001, 8'hFF, 1'b0, 1'b0);
    reset_check("reset");
    rst = 1'b0;

    // Single PUSH
    push_data = 8'h5A;
    drive(1'b1, 3'b001, 8'hFF, 1'b0, 1'b0);
    cyc("push", 2'b01, 1'b0, 1'b1, 1'b0, 8'hFF, 8'h5A, 2'b00);
    drive(1'b0, 3'b001, 8'hFE, 1'b0, 1'b0);
    idle_cyc("push_idle");

    // POP then RET back to back
    drive(1'b1, 3'b010, 8'hFD, 1'b0, 1'b0);
    cyc("pop", 2'b10, 1'b0, 1'b0, 1'b1, 8'hFE, 8'h00, 2'b00);
    drive(1'b1, 3'b100, 8'hFE, 1'b0, 1'b0);
    cyc("ret", 2'b10, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h00, 2'b01);

    // INT then RTI; pc_ret changes in beat 2 to prove the latch is used
    flags_in = 4'hA; pc_ret = 8'h33;
    drive(1'b1, 3'b110, 8'h80, 1'b0, 1'b0);
    cyc("int_b1", 2'b01, 1'b1, 1'b1, 1'b0, 8'h80, 8'h0A, 2'b00);
    pc_ret = 8'h99;
    drive(1'b1, 3'b110, 8'h7F, 1'b0, 1'b0);
    cyc("int_b2", 2'b01, 1'b1, 1'b1, 1'b0, 8'h7F, 8'h33, 2'b00);
    drive(1'b1, 3'b101, 8'h7E, 1'b0, 1'b0);
    cyc("rti_b1", 2'b10, 1'b1, 1'b0, 1'b1, 8'h7F, 8'h00, 2'b01);
    drive(1'b1, 3'b101, 8'h7F, 1'b0, 1'b0);
    cyc("rti_b2", 2'b10, 1'b1, 1'b0, 1'b1, 8'h80, 8'h00, 2'b10);
    drive(1'b0, 3'b000, 8'h80, 1'b0, 1'b0);
    idle_cyc("rti_idle");

    // sp_not_ready holds a PUSH for two cycles
    push_data = 8'h11;
    drive(1'b1, 3'b001, 8'h50, 1'b1, 1'b0);
    cyc("nr1", 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    cyc("nr2", 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    drive(1'b1, 3'b001, 8'h51, 1'b0, 1'b0);
    cyc("nr_fire", 2'b01, 1'b0, 1'b1, 1'b0, 8'h51, 8'h11, 2'b00);

    // Stall in IDLE and inactive codes
    drive(1'b1, 3'b001, 8'h50, 1'b0, 1'b1);
    idle_cyc("stall_idle");
    drive(1'b1, 3'b111, 8'h50, 1'b0, 1'b0);
    idle_cyc("code111");
    drive(1'b1, 3'b000, 8'h50, 1'b0, 1'b0);
    idle_cyc("code000");

    // Stall holds INT in BEAT2 for three cycles
    flags_in = 4'h5; pc_ret = 8'h77;
    drive(1'b1, 3'b110, 8'h40, 1'b0, 1'b0);
    cyc("sint_b1", 2'b01, 1'b1, 1'b1, 1'b0, 8'h40, 8'h05, 2'b00);
    drive(1'b1, 3'b110, 8'h3F, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc("sint_stall", 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'b00);
    drive(1'b1, 3'b110, 8'h3F, 1'b0, 1'b0);
    cyc("sint_b2", 2'b01, 1'b1, 1'b1, 1'b0, 8'h3F, 8'h77, 2'b00);
    drive(1'b0, 3'b000, 8'h3E, 1'b0, 1'b0);
    idle_cyc("sint_idle");

    // Wrap-around
    push_data = 8'hC3;
    drive(1'b1, 3'b001, 8'h00, 1'b0, 1'b0);
    cyc("wrap_push", 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 8'hC3, 2'b00);
    drive(1'b1, 3'b010, 8'hFF, 1'b0, 1'b0);
    cyc("wrap_pop", 2'b10, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 2'b00);

    // Reset inside RTI beat 2 abandons the second read
    drive(1'b1, 3'b101, 8'h10, 1'b0, 1'b0);
    cyc("rrti_b1", 2'b10, 1'b1, 1'b0, 1'b1, 8'h11, 8'h00, 2'b01);
    rst = 1'b1;
    drive(1'b1, 3'b101, 8'h11, 1'b0, 1'b0);
    reset_check("rst_b2");
    rst = 1'b0;
    drive(1'b0, 3'b000, 8'h11, 1'b0, 1'b0);
    idle_cyc("post_rst");
    drive(1'b1, 3'b010, 8'h20, 1'b0, 1'b0);
    cyc("post_rst_pop", 2'b10, 1'b0, 1'b0, 1'b1, 8'h21, 8'h00, 2'b00);

    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
